// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - shared handshake state encoding and word geometry for the multi-cycle CPU
package mcpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam int WORD_BYTES = 4;
   localparam int BYTE_SHIFT = $clog2(WORD_BYTES);

   function automatic int index_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mcpu_data_mem_if.sv
// rtl/mcpu_data_mem_if.sv - req/ack load/store bus between the CPU and the data memory
interface mcpu_data_mem_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        ack;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, we, addr, wdata, input busy, ack, rdata, err);
   modport slave  (input req, we, addr, wdata, output busy, ack, rdata, err);
endinterface

// File: rtl/mcpu_word_ram.sv
// rtl/mcpu_word_ram.sv - word-organised data RAM, synchronous write and combinational read
module mcpu_word_ram
   import mcpu_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = index_bits(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mcpu_data_mem.sv
// rtl/mcpu_data_mem.sv - wait-stated load/store responder for the multi-cycle CPU
module mcpu_data_mem
   import mcpu_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   mcpu_data_mem_if.slave   bus
);

   localparam int AW = index_bits(DEPTH_WORDS);

   generate
      if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
         $error("mcpu_data_mem: WAIT_CYCLES must be in 0..15");
      end
   endgenerate

   mem_state_t  state;
   logic [3:0]  cnt;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] word_addr;
   logic [31:0] ram_rdata;
   logic        bad;
   logic        commit;

   // Upper address bits take part in the range check so addresses never alias.
   assign word_addr = addr_q >> BYTE_SHIFT;
   assign bad       = (addr_q[BYTE_SHIFT-1:0] != '0) || (word_addr >= 32'(DEPTH_WORDS));
   assign commit    = (state == WAIT) && (cnt == 4'd0);

   mcpu_word_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .we    (commit & we_q & ~bad),
      .addr  (word_addr[AW-1:0]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // WAIT always lasts WAIT_CYCLES+1 cycles so ack rises WAIT_CYCLES+1 edges after accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         bus.busy  <= 1'b0;
         bus.ack   <= 1'b0;
         bus.err   <= 1'b0;
         bus.rdata <= '0;
      end else begin
         bus.ack <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req) begin
                  state    <= WAIT;
                  cnt      <= 4'(WAIT_CYCLES);
                  we_q     <= bus.we;
                  addr_q   <= bus.addr;
                  wdata_q  <= bus.wdata;
                  bus.busy <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state   <= RESP;
                  bus.ack <= 1'b1;
                  bus.err <= bad;
                  if (bad) begin
                     bus.rdata <= '0;
                  end else if (!we_q) begin
                     bus.rdata <= ram_rdata;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mcpu_data_mem.sv
// tb/tb_mcpu_data_mem.sv - self-checking bench for mcpu_data_mem at WAIT_CYCLES 2, 0 and 5
module tb_mcpu_data_mem;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mcpu_data_mem_if b0 ();
   mcpu_data_mem_if b1 ();
   mcpu_data_mem_if b2 ();

   mcpu_data_mem #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(b0));
   mcpu_data_mem #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
   mcpu_data_mem #(.DEPTH_WORDS(64), .WAIT_CYCLES(5)) dut2 (.clk(clk), .reset(reset), .bus(b2));

   int checks = 0;
   int errors = 0;
   int waits [3] = '{2, 0, 5};

   // Reference memory image and the rdata value each responder should be holding.
   logic [31:0] model   [3][64];
   logic [31:0] last_rd [3];

   function automatic bit exp_err(input logic [31:0] a);
      return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'd64);
   endfunction

   function automatic logic [31:0] exp_rd(input int d, input bit w, input logic [31:0] a);
      if (exp_err(a)) return 32'd0;
      if (w) return last_rd[d];
      return model[d][a[7:2]];
   endfunction

   task automatic model_apply(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd);
      if (exp_err(a)) last_rd[d] = 32'd0;
      else if (w) model[d][a[7:2]] = wd;
      else last_rd[d] = model[d][a[7:2]];
   endtask

   task automatic drive(input int d, input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd);
      case (d)
         0: begin b0.req = r; b0.we = w; b0.addr = a; b0.wdata = wd; end
         1: begin b1.req = r; b1.we = w; b1.addr = a; b1.wdata = wd; end
         default: begin b2.req = r; b2.we = w; b2.addr = a; b2.wdata = wd; end
      endcase
   endtask

   task automatic sample(input int d, output bit bz, output bit ak, output bit er, output logic [31:0] rd);
      case (d)
         0: begin bz = b0.busy; ak = b0.ack; er = b0.err; rd = b0.rdata; end
         1: begin bz = b1.busy; ak = b1.ack; er = b1.err; rd = b1.rdata; end
         default: begin bz = b2.busy; ak = b2.ack; er = b2.err; rd = b2.rdata; end
      endcase
   endtask

   // One access with req dropped right after ack; inputs are scrambled while the access is in flight.
   task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         output bit e, output logic [31:0] rd, output int lat,
                         output bit busy_ok, output bit tail_ok);
      bit bz, ak, er, seen;
      logic [31:0] r;
      drive(d, 1'b1, w, a, wd);
      @(posedge clk); #1;
      drive(d, 1'b1, 1'b1, a ^ 32'h4, ~wd);
      sample(d, bz, ak, er, r);
      busy_ok = bz && !ak;
      seen = 1'b0; lat = 0; e = 1'b0; rd = '0;
      while (!seen && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         sample(d, bz, ak, er, r);
         if (!bz) busy_ok = 1'b0;
         if (ak) begin seen = 1'b1; e = er; rd = r; end
      end
      drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
      if (!seen) begin
         checks++; errors++;
         $display("FAIL ack_timeout dut%0d addr=%h: no ack within 40 cycles", d, a);
         lat = -1;
      end
      @(posedge clk); #1;
      sample(d, bz, ak, er, r);
      tail_ok = !bz && !ak;
   endtask

   task automatic test_reset;
      bit bz, ak, er;
      logic [31:0] r;
      reset = 1'b0;
      for (int d = 0; d < 3; d++) drive(d, 1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF);
      for (int i = 0; i < 6; i++) begin
         #5;
         for (int d = 0; d < 3; d++) begin
            sample(d, bz, ak, er, r);
            checks++;
            if ({bz, ak, er} !== 3'b000 || r !== 32'd0) begin
               errors++;
               $display("FAIL reset_outputs dut%0d t=%0t busy=%b ack=%b err=%b rdata=%h, expected all zero",
                        d, $time, bz, ak, er, r);
            end
         end
      end
      for (int d = 0; d < 3; d++) begin
         drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
         last_rd[d] = 32'd0;
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_init;
      bit e, bo, to;
      logic [31:0] rd, wd;
      int lat;
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            access(d, 1'b1, 32'(i * 4), wd, e, rd, lat, bo, to);
            checks++;
            if (e !== 1'b0 || rd !== last_rd[d]) begin
               errors++;
               $display("FAIL init_store dut%0d word=%0d err=%b rdata=%h, expected err=0 rdata=%h",
                        d, i, e, rd, last_rd[d]);
            end
            model_apply(d, 1'b1, 32'(i * 4), wd);
         end
      end
   endtask

   task automatic test_store_load;
      bit e, bo, to;
      logic [31:0] rd;
      int lat;
      access(0, 1'b1, 32'h8, 32'hDEAD_BEEF, e, rd, lat, bo, to);
      checks++;
      if (lat != 3 || e !== 1'b0 || rd !== last_rd[0]) begin
         errors++;
         $display("FAIL store_0x08 latency=%0d err=%b rdata=%h, expected latency=3 err=0 rdata=%h",
                  lat, e, rd, last_rd[0]);
      end
      model_apply(0, 1'b1, 32'h8, 32'hDEAD_BEEF);
      access(0, 1'b0, 32'h8, 32'h0, e, rd, lat, bo, to);
      checks++;
      if (lat != 3 || e !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL load_0x08 latency=%0d err=%b rdata=%h, expected latency=3 err=0 rdata=deadbeef",
                  lat, e, rd);
      end
      model_apply(0, 1'b0, 32'h8, 32'h0);
   endtask

   task automatic test_latency;
      bit e, bo, to;
      logic [31:0] rd, a, wd, x;
      int lat;
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 2; k++) begin
            a  = 32'($urandom_range(0, 63) * 4);
            wd = $urandom;
            x  = exp_rd(d, k == 0, a);
            access(d, k == 0, a, wd, e, rd, lat, bo, to);
            checks++;
            if (lat != waits[d] + 1) begin
               errors++;
               $display("FAIL latency dut%0d got %0d cycles, expected %0d", d, lat, waits[d] + 1);
            end
            checks++;
            if (!bo || !to) begin
               errors++;
               $display("FAIL busy_window dut%0d busy_through_ack=%b idle_after=%b, expected 1 and 1", d, bo, to);
            end
            checks++;
            if (e !== 1'b0 || rd !== x) begin
               errors++;
               $display("FAIL latency_data dut%0d err=%b rdata=%h, expected err=0 rdata=%h", d, e, rd, x);
            end
            model_apply(d, k == 0, a, wd);
         end
      end
   endtask

   task automatic test_errors;
      logic [31:0] addrs [9] = '{32'h06, 32'h100, 32'h00, 32'h4000_0000, 32'h00,
                                 32'hFC, 32'hFC, 32'hFF, 32'hFFFF_FFFC};
      bit          wes   [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      bit e, bo, to, xe;
      logic [31:0] rd, wd, xr;
      int lat;
      for (int i = 0; i < 9; i++) begin
         wd = $urandom;
         xe = exp_err(addrs[i]);
         xr = exp_rd(0, wes[i], addrs[i]);
         access(0, wes[i], addrs[i], wd, e, rd, lat, bo, to);
         checks++;
         if (e !== xe || rd !== xr || lat != 3) begin
            errors++;
            $display("FAIL error_case addr=%h we=%b err=%b rdata=%h latency=%0d, expected err=%b rdata=%h latency=3",
                     addrs[i], wes[i], e, rd, lat, xe, xr);
         end
         model_apply(0, wes[i], addrs[i], wd);
      end
   endtask

   task automatic test_reset_mid;
      bit bz, ak, er, e, bo, to, ack_seen;
      logic [31:0] r, rd, old;
      int lat;
      old = model[0][4];
      drive(0, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
      @(posedge clk); #1;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      sample(0, bz, ak, er, r);
      checks++;
      if (bz !== 1'b0 || ak !== 1'b0 || r !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs busy=%b ack=%b rdata=%h, expected 0 0 0", bz, ak, r);
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int d = 0; d < 3; d++) last_rd[d] = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      ack_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         sample(0, bz, ak, er, r);
         if (ak || bz) ack_seen = 1'b1;
      end
      checks++;
      if (ack_seen) begin
         errors++;
         $display("FAIL reset_mid_abandon ack_or_busy_seen=1, expected 0");
      end
      access(0, 1'b0, 32'h10, 32'h0, e, rd, lat, bo, to);
      checks++;
      if (e !== 1'b0 || rd !== old) begin
         errors++;
         $display("FAIL reset_mid_store_lost rdata=%h err=%b, expected rdata=%h err=0", rd, e, old);
      end
      model_apply(0, 1'b0, 32'h10, 32'h0);
   endtask

   task automatic test_back_to_back;
      int w, lat, guard;
      int ack_at [$];
      logic [31:0] ack_rd [$];
      logic [31:0] a1, b, wd1, junk, rd, r, first_x;
      bit bz, ak, er, e, bo, to;
      w    = waits[0];
      a1   = 32'($urandom_range(0, 63) * 4);
      b    = a1 ^ 32'h4;
      wd1  = $urandom;
      junk = ~wd1;
      first_x = last_rd[0];
      drive(0, 1'b1, 1'b1, a1, wd1);
      for (int k = 0; k <= 2 * w + 5; k++) begin
         @(posedge clk); #1;
         sample(0, bz, ak, er, r);
         if (ak) begin ack_at.push_back(k); ack_rd.push_back(r); end
         if (k == w + 2) drive(0, 1'b1, 1'b0, a1, junk);
         else if (k >= 2 * w + 4) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
         else drive(0, 1'b1, 1'b1, b, junk);
      end
      guard = 0;
      sample(0, bz, ak, er, r);
      while (bz && guard < 40) begin
         @(posedge clk); #1;
         sample(0, bz, ak, er, r);
         guard++;
      end
      model_apply(0, 1'b1, a1, wd1);
      model_apply(0, 1'b0, a1, 32'h0);
      checks++;
      if (ack_at.size() != 2) begin
         errors++;
         $display("FAIL b2b_ack_count got %0d acks, expected 2", ack_at.size());
      end else begin
         checks++;
         if (ack_at[0] != w + 1 || ack_at[1] != 2 * w + 4) begin
            errors++;
            $display("FAIL b2b_ack_timing acks at %0d,%0d, expected %0d,%0d",
                     ack_at[0], ack_at[1], w + 1, 2 * w + 4);
         end
         checks++;
         if (ack_rd[0] !== first_x || ack_rd[1] !== wd1) begin
            errors++;
            $display("FAIL b2b_data rdata %h,%h, expected %h,%h", ack_rd[0], ack_rd[1], first_x, wd1);
         end
      end
      access(0, 1'b0, b, 32'h0, e, rd, lat, bo, to);
      checks++;
      if (rd !== model[0][b[7:2]] || e !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_extra_accept addr=%h rdata=%h, expected %h", b, rd, model[0][b[7:2]]);
      end
      model_apply(0, 1'b0, b, 32'h0);
   endtask

   task automatic test_random;
      bit w, e, bo, to, xe;
      logic [31:0] a, wd, rd, xr;
      int lat, sel;
      for (int d = 0; d < 3; d++) begin
         for (int n = 0; n < 40; n++) begin
            w   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'($urandom_range(0, 63) * 4);
            else if (sel == 7) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else if (sel == 8) a = 32'($urandom_range(64, 127) * 4);
            else               a = $urandom;
            wd = $urandom;
            xe = exp_err(a);
            xr = exp_rd(d, w, a);
            access(d, w, a, wd, e, rd, lat, bo, to);
            checks++;
            if (e !== xe || rd !== xr || lat != waits[d] + 1 || !bo || !to) begin
               errors++;
               $display("FAIL random dut%0d we=%b addr=%h err=%b rdata=%h lat=%0d busy_ok=%b tail_ok=%b, expected err=%b rdata=%h lat=%0d",
                        d, w, a, e, rd, lat, bo, to, xe, xr, waits[d] + 1);
            end
            model_apply(d, w, a, wd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_store_load();
      test_latency();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
